fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pulls words out of an upstream FIFO with a fixed 1-cycle read
// latency and replays them as a valid/ready stream through a 2-entry skid buffer.
// Reads are credit-gated so a returning word always finds a free slot.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_empty,
    output logic                  f_ren,
    input  logic                  f_rvalid,
    input  logic [DATA_WIDTH-1:0] f_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [1:0]            occupancy
);
    localparam logic [2:0] DEPTH_CREDITS = 3'(BUF_DEPTH);

    logic [1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic [1:0]                 occ_q, occ_d;
    logic                       inflight_q, inflight_d;
    logic                       armed_q, armed_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       err_unexp_q, err_unexp_d;
    logic                       err_unexp;
    logic                       push, pop;
    logic [2:0]                 credit_used;

    // Stream side is decoded straight from registers, never from f_rdata.
    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = mem_q[rd_ptr_q];
    assign occupancy = occ_q;
    assign beat_cnt  = cnt_q;
    // Sticky flag: a read-data beat showed up with no read outstanding.
    assign err_unexp = err_unexp_q;

    // Issue a read only if the buffer can absorb everything already committed.
    // armed_q keeps f_ren low until the first edge after reset is released.
    always_comb begin
        pop         = m_valid & m_ready;
        push        = f_rvalid & inflight_q;
        credit_used = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
        f_ren       = armed_q & ~f_empty & (credit_used < DEPTH_CREDITS);
    end

    // Next-state: buffer write/read pointers, occupancy, counters and flags.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        cnt_d       = cnt_q;
        armed_d     = 1'b1;
        // Read latency is exactly one cycle, so the next outstanding state is this f_ren.
        inflight_d  = f_ren;
        // Suppressed during the armed_q=0 cycle so a stale return right after reset is quiet.
        err_unexp_d = err_unexp | (f_rvalid & ~inflight_q & armed_q);
        if (push) begin
            mem_d[wr_ptr_q] = f_rdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; reset drops buffered and in-flight data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            err_unexp_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            err_unexp_q <= err_unexp_d;
        end
    end
endmodule
